// File: rtl/qam_pkg.sv
// Shared types and widths for the 16QAM demapper read-side sequencer.
package qam_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/qam_nibble_packer.sv
// Packs two demapped nibbles into a byte (high nibble first) and holds the
// byte on a valid/ready stage until downstream accepts it. A flush discards
// any half-built or unaccepted byte.
module qam_nibble_packer
  import qam_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                cap,
  input  logic [NIBBLE_W-1:0] nib,
  input  logic                ready,
  output logic [BYTE_W-1:0]   byte_data,
  output logic                byte_valid,
  output logic                handshake
);

  logic                phase;
  logic [NIBBLE_W-1:0] hi_nib;

  assign handshake = byte_valid && ready;

  // Phase tracking, high-nibble staging and the output holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      hi_nib     <= {NIBBLE_W{1'b0}};
      byte_data  <= {BYTE_W{1'b0}};
      byte_valid <= 1'b0;
    end else if (flush) begin
      phase      <= 1'b0;
      hi_nib     <= {NIBBLE_W{1'b0}};
      byte_data  <= {BYTE_W{1'b0}};
      byte_valid <= 1'b0;
    end else begin
      if (cap && !phase) begin
        hi_nib <= nib;
        phase  <= 1'b1;
      end
      // A completing nibble takes priority; reads are throttled upstream so
      // it never lands on top of a byte that is still waiting for ready.
      if (cap && phase) begin
        byte_data  <= {hi_nib, nib};
        byte_valid <= 1'b1;
        phase      <= 1'b0;
      end else if (handshake) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/qam_frame_controller.sv
// Read-side sequencer for the 16QAM demapper path (dclk domain): holds the
// demapper/FIFO in clear while idle, drains nibbles one read at a time, packs
// them into bytes and counts a fixed-length frame.
// Build option: define QAM_OVF_ABORT_EN to end the frame early (DONE) when
// the FIFO is seen full during RUN; otherwise overflow is status only.
module qam_frame_controller
  import qam_pkg::*;
#(
  parameter int FRAME_BYTES = 64,
  parameter int CLR_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                dclk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic                fifo_full,
  input  logic [NIBBLE_W-1:0] fifo_q,
  output logic                fifo_rdreq,
  output logic                demap_clr,
  output logic [BYTE_W-1:0]   byte_data,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                available,
  output logic                complete,
  output logic                overflow
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int NIB_W = CNT_W + 1;
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(FRAME_BYTES - 1);
  localparam logic [NIB_W-1:0] NIB_TOTAL = NIB_W'(2 * FRAME_BYTES);

  state_t           state;
  state_t           next_state;
  logic [CLR_W-1:0] clr_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [NIB_W-1:0] nib_cnt;
  logic             rd_pend;
  logic             last_issued;
  logic             handshake;
  logic             flush;
  logic             cap;

  assign last_issued = (nib_cnt == NIB_TOTAL);
  assign fifo_rdreq  = (state == RUN) && !fifo_empty && !rd_pend &&
                       !(byte_valid && !byte_ready) && !last_issued;
  assign available   = (state == RUN) && !fifo_empty;
  assign cap         = rd_pend && (state == RUN);
  // Leaving RUN for any reason discards the partial/unaccepted byte.
  assign flush       = (next_state != RUN);

  // Next-state decode; enable low always wins and returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable) next_state = CLEAR;
        else        next_state = IDLE;
      end
      CLEAR: begin
        if (!enable)                 next_state = IDLE;
        else if (clr_cnt == CLR_LAST) next_state = RUN;
        else                          next_state = CLEAR;
      end
      RUN: begin
        if (!enable)                                  next_state = IDLE;
        else if (handshake && (byte_cnt == BYTE_LAST)) next_state = DONE;
`ifdef QAM_OVF_ABORT_EN
        else if (fifo_full)                           next_state = DONE;
`endif
        else                                          next_state = RUN;
      end
      DONE: begin
        if (!enable) next_state = IDLE;
        else         next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, counters, read-pending flag and registered status outputs.
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_cnt   <= {CLR_W{1'b0}};
      byte_cnt  <= {CNT_W{1'b0}};
      nib_cnt   <= {NIB_W{1'b0}};
      rd_pend   <= 1'b0;
      overflow  <= 1'b0;
      complete  <= 1'b0;
      demap_clr <= 1'b1;
    end else begin
      state     <= next_state;
      rd_pend   <= fifo_rdreq;
      complete  <= (next_state == DONE);
      demap_clr <= (next_state == IDLE) || (next_state == CLEAR);
      if ((state == IDLE) && enable) begin
        clr_cnt  <= {CLR_W{1'b0}};
        byte_cnt <= {CNT_W{1'b0}};
        nib_cnt  <= {NIB_W{1'b0}};
        overflow <= 1'b0;
      end else begin
        if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        if (fifo_rdreq) nib_cnt <= nib_cnt + 1'b1;
        if (handshake && (state == RUN)) byte_cnt <= byte_cnt + 1'b1;
        if ((state == RUN) && fifo_full) overflow <= 1'b1;
      end
    end
  end

  qam_nibble_packer u_packer (
    .clk        (dclk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cap        (cap),
    .nib        (fifo_q),
    .ready      (byte_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .handshake  (handshake)
  );

endmodule

// File: tb/tb_qam_frame_controller.sv
// Bench for qam_frame_controller with a small FIFO model and an expected-byte
// scoreboard. DUT built with FRAME_BYTES=2, CLR_CYCLES=4.
module tb_qam_frame_controller;

  logic       dclk = 1'b0;
  logic       rst_n, enable, fifo_empty, fifo_full, byte_ready;
  logic [3:0] fifo_q = 4'h0;
  logic       fifo_rdreq, demap_clr, byte_valid, available, complete, overflow;
  logic [7:0] byte_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  logic [3:0] mem[0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_count = 0;
  int         consec_cnt = 0;
  logic       prev_rd = 1'b0;

  always #5 dclk = ~dclk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  qam_frame_controller #(.FRAME_BYTES(2), .CLR_CYCLES(4), .CNT_W(16)) dut (
    .dclk(dclk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .demap_clr(demap_clr), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .available(available), .complete(complete),
    .overflow(overflow)
  );

  // FIFO model: show-ahead-free read, data one cycle after rdreq; clear flushes.
  always @(posedge dclk) begin
    if (demap_clr === 1'b1) rd_ptr <= wr_ptr;
    else if (fifo_rdreq === 1'b1 && rd_ptr != wr_ptr) begin
      fifo_q <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Read-request monitor: total count and back-to-back occurrences.
  always @(posedge dclk) begin
    if (fifo_rdreq === 1'b1) rd_count <= rd_count + 1;
    if (fifo_rdreq === 1'b1 && prev_rd) consec_cnt <= consec_cnt + 1;
    prev_rd <= (fifo_rdreq === 1'b1);
  end

  task automatic tick();
    @(negedge dclk);
  endtask

  task automatic push_nib(input logic [3:0] n);
    mem[wr_ptr[7:0]] = n;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic start_frame();
    enable = 1'b0; byte_ready = 1'b0; fifo_full = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    enable = 1'b1;
    for (int i = 0; i < 20 && demap_clr; i++) tick();
    checks++;
    if (demap_clr !== 1'b0) begin
      errors++; $display("FAIL start_frame demap_clr=%b required 0", demap_clr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; fifo_full = 1'b0; byte_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({demap_clr, fifo_rdreq, byte_valid, byte_data, available, complete, overflow} !== 14'b10_0000_0000_0000) begin
      errors++;
      $display("FAIL reset_state got clr=%b rd=%b v=%b d=%h av=%b c=%b ov=%b required clr=1 rest 0",
               demap_clr, fifo_rdreq, byte_valid, byte_data, available, complete, overflow);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (demap_clr !== 1'b1 || fifo_rdreq !== 1'b0) begin
      errors++; $display("FAIL idle_hold clr=%b rd=%b required 1/0", demap_clr, fifo_rdreq);
    end
  endtask

  task automatic test_clear();
    int hi = 0;
    int rd_seen = 0;
    enable = 1'b0; repeat (2) tick();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (demap_clr) begin
        hi++;
        push_nib(4'hF);
        #1;
        if (fifo_rdreq) rd_seen++;
      end else break;
    end
    checks++;
    if (hi != 4) begin errors++; $display("FAIL clear_len got %0d required 4", hi); end
    checks++;
    if (rd_seen != 0) begin errors++; $display("FAIL clear_rdreq got %0d required 0", rd_seen); end
    push_nib(4'h1);
    #1;
    checks++;
    if (available !== 1'b1 || fifo_rdreq !== 1'b1) begin
      errors++; $display("FAIL run_first_read av=%b rd=%b required 1/1", available, fifo_rdreq);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int got = 0;
    int rd0, cons0;
    logic [7:0] e;
    start_frame();
    byte_ready = 1'b1;
    rd0 = rd_count; cons0 = consec_cnt;
    push_nib(4'hA); push_nib(4'h5); push_nib(4'h3); push_nib(4'hC);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    for (int i = 0; i < 60; i++) begin
      if (byte_valid && byte_ready) begin
        got++; checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (byte_data !== e) begin errors++; $display("FAIL basic_byte got %h required %h", byte_data, e); end
      end
      if (complete) break;
      tick();
    end
    checks++;
    if (got != 2 || complete !== 1'b1) begin
      errors++; $display("FAIL basic_frame bytes=%0d complete=%b required 2/1", got, complete);
    end
    checks++;
    if (rd_count - rd0 != 4) begin errors++; $display("FAIL basic_rdreqs got %0d required 4", rd_count - rd0); end
    checks++;
    if (consec_cnt != cons0) begin errors++; $display("FAIL basic_consecutive got %0d required 0", consec_cnt - cons0); end
  endtask

  task automatic test_stall();
    int got = 0;
    int bad = 0;
    int snap;
    logic [7:0] e;
    start_frame();
    push_nib(4'hA); push_nib(4'h5); push_nib(4'h3); push_nib(4'hC);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    for (int i = 0; i < 30 && !byte_valid; i++) tick();
    checks++;
    if (byte_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b required 1", byte_valid); end
    snap = rd_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (byte_valid !== 1'b1 || byte_data !== 8'hA5) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_stable unstable_cycles=%0d required 0", bad); end
    checks++;
    if (rd_count != snap) begin errors++; $display("FAIL stall_rdreq got %0d required 0", rd_count - snap); end
    byte_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (byte_valid && byte_ready) begin
        got++; checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (byte_data !== e) begin errors++; $display("FAIL stall_byte got %h required %h", byte_data, e); end
      end
      if (complete) break;
      tick();
    end
    checks++;
    if (got != 2 || complete !== 1'b1) begin
      errors++; $display("FAIL stall_frame bytes=%0d complete=%b required 2/1", got, complete);
    end
  endtask

  task automatic test_frame_len();
    int got = 0;
    int rd0;
    logic [7:0] e;
    start_frame();
    byte_ready = 1'b1;
    rd0 = rd_count;
    for (int n = 1; n <= 6; n++) push_nib(4'(n));
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    for (int i = 0; i < 60; i++) begin
      if (byte_valid && byte_ready) begin
        got++; checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (byte_data !== e) begin errors++; $display("FAIL frame_byte got %h required %h", byte_data, e); end
      end
      if (complete) break;
      tick();
    end
    repeat (5) tick();
    checks++;
    if (rd_count - rd0 != 4) begin errors++; $display("FAIL frame_rdreqs got %0d required 4", rd_count - rd0); end
    checks++;
    if (wr_ptr - rd_ptr != 2) begin errors++; $display("FAIL frame_leftover got %0d required 2", wr_ptr - rd_ptr); end
    checks++;
    if (complete !== 1'b1 || byte_valid !== 1'b0 || fifo_rdreq !== 1'b0 || got != 2) begin
      errors++; $display("FAIL frame_done c=%b v=%b rd=%b bytes=%0d required 1/0/0/2", complete, byte_valid, fifo_rdreq, got);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (complete !== 1'b0 || demap_clr !== 1'b1) begin
      errors++; $display("FAIL frame_exit c=%b clr=%b required 0/1", complete, demap_clr);
    end
  endtask

  task automatic test_abort();
    int got = 0;
    int rd0;
    logic [7:0] e;
    start_frame();
    byte_ready = 1'b1;
    rd0 = rd_count;
    push_nib(4'hA); push_nib(4'h5); push_nib(4'hB);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 60 && got < 1; i++) begin
      if (byte_valid && byte_ready) begin
        got++; checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (byte_data !== e) begin errors++; $display("FAIL abort_first got %h required %h", byte_data, e); end
      end
      tick();
    end
    for (int i = 0; i < 30 && (rd_count - rd0) < 3; i++) tick();
    repeat (2) tick();
    enable = 1'b0;
    tick();
    checks++;
    if ({byte_valid, demap_clr, complete} !== 3'b010 || got != 1) begin
      errors++; $display("FAIL abort_idle v=%b clr=%b c=%b bytes=%0d required 0/1/0/1", byte_valid, demap_clr, complete, got);
    end
    got = 0;
    start_frame();
    byte_ready = 1'b1;
    push_nib(4'h9); push_nib(4'h8); push_nib(4'h7); push_nib(4'h6);
    exp_q.push_back(8'h98); exp_q.push_back(8'h76);
    for (int i = 0; i < 60; i++) begin
      if (byte_valid && byte_ready) begin
        got++; checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (byte_data !== e) begin errors++; $display("FAIL abort_rerun_byte got %h required %h", byte_data, e); end
      end
      if (complete) break;
      tick();
    end
    checks++;
    if (got != 2 || complete !== 1'b1) begin
      errors++; $display("FAIL abort_rerun bytes=%0d complete=%b required 2/1", got, complete);
    end
  endtask

  task automatic test_overflow();
    int got = 0;
    int rd0;
    logic [7:0] e;
    start_frame();
    byte_ready = 1'b1;
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b required 1", overflow); end
`ifdef QAM_OVF_ABORT_EN
    checks++;
    if (complete !== 1'b1 || byte_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_abort c=%b v=%b required 1/0", complete, byte_valid);
    end
    rd0 = rd_count;
    push_nib(4'hA); push_nib(4'h5);
    repeat (6) tick();
    checks++;
    if (rd_count != rd0 || complete !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_done rd=%0d c=%b ov=%b required 0/1/1", rd_count - rd0, complete, overflow);
    end
`else
    checks++;
    if (complete !== 1'b0) begin errors++; $display("FAIL ovf_noabort c=%b required 0", complete); end
    rd0 = rd_count;
    push_nib(4'hA); push_nib(4'h5); push_nib(4'h3); push_nib(4'hC);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    for (int i = 0; i < 60; i++) begin
      if (byte_valid && byte_ready) begin
        got++; checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (byte_data !== e) begin errors++; $display("FAIL ovf_byte got %h required %h", byte_data, e); end
      end
      if (complete) break;
      tick();
    end
    checks++;
    if (got != 2 || complete !== 1'b1 || overflow !== 1'b1 || rd_count - rd0 != 4) begin
      errors++; $display("FAIL ovf_frame bytes=%0d c=%b ov=%b rd=%0d required 2/1/1/4", got, complete, overflow, rd_count - rd0);
    end
`endif
    enable = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", overflow); end
    start_frame();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b required 0", overflow); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    start_frame();
    push_nib(4'hA); push_nib(4'h5);
    for (int i = 0; i < 30 && !byte_valid; i++) tick();
    checks++;
    if (byte_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre v=%b required 1", byte_valid); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({byte_valid, demap_clr, complete, fifo_rdreq} !== 4'b0100 || byte_data !== 8'h00) begin
      errors++; $display("FAIL midrst v=%b clr=%b c=%b rd=%b d=%h required 0/1/0/0/00",
                         byte_valid, demap_clr, complete, fifo_rdreq, byte_data);
    end
    rst_n = 1'b1; enable = 1'b0;
    exp_q.delete();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; fifo_full = 1'b0; byte_ready = 1'b0;
    test_reset();
    test_clear();
    test_basic();
    test_stall();
    test_frame_len();
    test_abort();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
